// File: rtl/btn_bcd_counter_bank_pkg.sv
// Shared constants and helpers for the push-button digit counter bank.
package btn_bcd_counter_bank_pkg;

    // Digit storage width and the supported parameter ranges.
    localparam int DIGIT_W     = 4;
    localparam int N_CH_MAX    = 8;
    localparam int MOD_MAX     = 16;
    localparam int DEB_LEN_MAX = 255;

    // Debounce counter wide enough for the longest stability window.
    localparam int DEB_CNT_W = $clog2(DEB_LEN_MAX + 1);

    // Counting mode selected by the chain input.
    typedef enum logic {
        MODE_INDEP = 1'b0,
        MODE_CHAIN = 1'b1
    } mode_e;

    // Next value of one digit when it is stepped; 'wrapped' says the step
    // crosses the modulus boundary (top -> 0 going up, 0 -> top going down).
    function automatic logic [DIGIT_W-1:0] digit_step(
        input logic [DIGIT_W-1:0] d,
        input logic               up,
        input logic               wrapped,
        input logic [DIGIT_W-1:0] top
    );
        if (up) begin
            return wrapped ? '0 : d + DIGIT_W'(1);
        end
        return wrapped ? top : d - DIGIT_W'(1);
    endfunction

endpackage

// File: rtl/btn_bcd_counter_bank_debounce.sv
// One button channel: 2-FF synchroniser, stability-count debouncer sampled
// on ce, and a one-clock pulse on the debounced rising edge.
module btn_debounce_edge
    import btn_bcd_counter_bank_pkg::*;
#(
    parameter int DEB_LEN = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic i_ce,
    input  logic i_btn,
    output logic o_press
);

    // The counter fires on the sample that would bring it to DEB_LEN.
    localparam logic [DEB_CNT_W-1:0] CNT_LAST = DEB_CNT_W'(DEB_LEN - 1);

    logic                 r_sync1;
    logic                 r_sync2;
    logic                 r_stable;
    logic                 r_press;
    logic [DEB_CNT_W-1:0] r_cnt;

    // Bring the asynchronous button into the clock domain.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
        end
    end

    // Accept a new level only after it holds for DEB_LEN ce-samples; any
    // bounce back to the accepted level restarts the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= '0;
            r_stable <= 1'b0;
            r_press  <= 1'b0;
        end else begin
            r_press <= 1'b0;
            if (r_sync2 == r_stable) begin
                r_cnt <= '0;
            end else if (i_ce) begin
                if (r_cnt == CNT_LAST) begin
                    r_cnt    <= '0;
                    r_stable <= r_sync2;
                    r_press  <= r_sync2;
                end else begin
                    r_cnt <= r_cnt + DEB_CNT_W'(1);
                end
            end
        end
    end

    assign o_press = r_press;

endmodule

// File: rtl/btn_bcd_counter_bank.sv
// Bank of debounced push buttons, each stepping a modulo-MOD digit, with an
// optional cascaded mode that turns the digits into one multi-digit counter.
module btn_bcd_counter_bank
    import btn_bcd_counter_bank_pkg::*;
#(
    parameter int N_CH    = 4,
    parameter int MOD     = 10,
    parameter int DEB_LEN = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ce,
    input  logic [N_CH-1:0]         btn,
    input  logic                    up,
    input  logic                    chain,
    input  logic                    clr,
    output logic [N_CH-1:0]         press,
    output logic [DIGIT_W*N_CH-1:0] dec,
    output logic [N_CH-1:0]         wrap
);

    // Reject out-of-range configurations at elaboration.
    if (N_CH < 1 || N_CH > N_CH_MAX || MOD < 2 || MOD > MOD_MAX ||
        DEB_LEN < 1 || DEB_LEN > DEB_LEN_MAX) begin : g_param_check
        $error("btn_bcd_counter_bank: parameter out of range");
    end

    localparam logic [DIGIT_W-1:0] DIGIT_TOP = DIGIT_W'(MOD - 1);

    logic [N_CH-1:0]    w_press;
    logic [DIGIT_W-1:0] r_dec [N_CH];
    logic [DIGIT_W-1:0] w_dec_next [N_CH];
    logic [N_CH-1:0]    r_wrap;
    logic [N_CH-1:0]    w_wrap_next;
    mode_e              w_mode;

    assign w_mode = mode_e'(chain);

    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
            btn_debounce_edge #(
                .DEB_LEN (DEB_LEN)
            ) u_debounce (
                .clk     (clk),
                .rst     (rst),
                .i_ce    (ce),
                .i_btn   (btn[gi]),
                .o_press (w_press[gi])
            );

            assign dec[DIGIT_W*gi +: DIGIT_W] = r_dec[gi];
        end
    endgenerate

    // Ripple from the LSD upward: work out which digits step this cycle and
    // their new values. In chain mode only the lowest press is taken and a
    // wrap carries (or borrows) into the next digit within the same edge.
    always_comb begin : ripple
        logic found;
        logic carry;
        logic step;
        logic wrapped;
        found       = 1'b0;
        carry       = 1'b0;
        step        = 1'b0;
        wrapped     = 1'b0;
        w_wrap_next = '0;
        for (int i = 0; i < N_CH; i++) begin
            w_dec_next[i] = r_dec[i];
            if (w_mode == MODE_CHAIN) begin
                step = (w_press[i] && !found) || carry;
            end else begin
                step = w_press[i];
            end
            if (w_press[i]) begin
                found = 1'b1;
            end
            wrapped = step && (up ? (r_dec[i] == DIGIT_TOP) : (r_dec[i] == '0));
            if (step) begin
                w_dec_next[i] = digit_step(r_dec[i], up, wrapped, DIGIT_TOP);
            end
            w_wrap_next[i] = wrapped;
            carry          = (w_mode == MODE_CHAIN) && wrapped;
        end
    end

    // Digit register; clear beats any same-cycle press and suppresses wrap.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            for (int i = 0; i < N_CH; i++) begin
                r_dec[i] <= '0;
            end
            r_wrap <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                r_dec[i] <= w_dec_next[i];
            end
            r_wrap <= w_wrap_next;
        end
    end

    assign press = w_press;
    assign wrap  = r_wrap;

endmodule

// File: tb/tb_btn_bcd_counter_bank.sv
// Directed bench for the push-button digit counter bank (N_CH=4, MOD=10, DEB_LEN=3).
`timescale 1ns/1ps
module tb_btn_bcd_counter_bank;

    logic        clk = 1'b0;
    logic        rst;
    logic        ce;
    logic [3:0]  btn;
    logic        up;
    logic        chain;
    logic        clr;
    logic [3:0]  press;
    logic [15:0] dec;
    logic [3:0]  wrap;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    btn_bcd_counter_bank #(
        .N_CH    (4),
        .MOD     (10),
        .DEB_LEN (3)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .ce    (ce),
        .btn   (btn),
        .up    (up),
        .chain (chain),
        .clr   (clr),
        .press (press),
        .dec   (dec),
        .wrap  (wrap)
    );

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hold buttons until the press pulse appears (bounded), then run the
    // update edge, optionally with clr asserted on it. Buttons stay held.
    task automatic hit(input logic [3:0] mask, input logic with_clr,
                       output logic [3:0] seen, output logic timed_out);
        btn       = mask;
        seen      = '0;
        timed_out = 1'b1;
        for (int n = 0; n < 20; n++) begin
            tick();
            if (press != 4'b0) begin
                seen      = press;
                timed_out = 1'b0;
                break;
            end
        end
        clr = with_clr;
        tick();
        clr = 1'b0;
    endtask

    // Release all buttons and count press pulses while they settle.
    task automatic release_all(output int pulses);
        btn    = '0;
        pulses = 0;
        repeat (10) begin
            tick();
            if (press != 4'b0) pulses++;
        end
    endtask

    // Setup-only press/release used to move digits to a starting value.
    task automatic step(input logic [3:0] mask);
        logic [3:0] seen;
        logic       to;
        int         p;
        hit(mask, 1'b0, seen, to);
        release_all(p);
    endtask

    task automatic test_reset();
        rst = 1'b1; ce = 1'b1; btn = '0; up = 1'b1; chain = 1'b0; clr = 1'b0;
        repeat (3) tick();
        checks++;
        if (press !== 4'b0) begin errors++; $display("FAIL reset_press got %b want 0000", press); end
        checks++;
        if (dec !== 16'h0000) begin errors++; $display("FAIL reset_dec got %h want 0000", dec); end
        checks++;
        if (wrap !== 4'b0) begin errors++; $display("FAIL reset_wrap got %b want 0000", wrap); end
        rst = 1'b0;
        repeat (3) tick();
        $display("reset: dec=%h press=%b wrap=%b", dec, press, wrap);
    endtask

    task automatic test_latency();
        int p;
        up = 1'b1; chain = 1'b0;
        btn = 4'b0001;
        for (int e = 1; e <= 4; e++) begin
            tick();
            checks++;
            if (press !== 4'b0) begin errors++; $display("FAIL latency_early edge %0d got %b want 0000", e, press); end
        end
        tick();
        checks++;
        if (press !== 4'b0001) begin errors++; $display("FAIL latency_press edge 5 got %b want 0001", press); end
        checks++;
        if (dec !== 16'h0000) begin errors++; $display("FAIL latency_dec_hold edge 5 got %h want 0000", dec); end
        tick();
        checks++;
        if (press !== 4'b0) begin errors++; $display("FAIL latency_pulse_width edge 6 got %b want 0000", press); end
        checks++;
        if (dec !== 16'h0001) begin errors++; $display("FAIL latency_dec edge 6 got %h want 0001", dec); end
        release_all(p);
        checks++;
        if (p != 0) begin errors++; $display("FAIL release_no_pulse got %0d want 0", p); end
        $display("latency: dec=%h", dec);
    endtask

    task automatic test_glitch();
        int p;
        up = 1'b1; chain = 1'b0;
        btn = 4'b0010;
        repeat (2) tick();
        btn = '0;
        p = 0;
        repeat (10) begin tick(); if (press != 4'b0) p++; end
        checks++;
        if (p != 0) begin errors++; $display("FAIL glitch_2_pulses got %0d want 0", p); end
        checks++;
        if (dec !== 16'h0001) begin errors++; $display("FAIL glitch_2_dec got %h want 0001", dec); end
        btn = 4'b0010;
        repeat (3) tick();
        btn = '0;
        p = 0;
        repeat (15) begin tick(); if (press[1]) p++; end
        checks++;
        if (p != 1) begin errors++; $display("FAIL glitch_3_pulses got %0d want 1", p); end
        checks++;
        if (dec !== 16'h0011) begin errors++; $display("FAIL glitch_3_dec got %h want 0011", dec); end
        $display("glitch: dec=%h", dec);
    endtask

    task automatic test_indep_wrap();
        logic [3:0] seen;
        logic       to;
        int         p;
        up = 1'b0; chain = 1'b0;
        hit(4'b0100, 1'b0, seen, to);
        checks++;
        if (to || seen !== 4'b0100) begin errors++; $display("FAIL indep_press got %b timeout %0d want 0100", seen, to); end
        checks++;
        if (dec !== 16'h0911) begin errors++; $display("FAIL indep_dec got %h want 0911", dec); end
        checks++;
        if (wrap !== 4'b0100) begin errors++; $display("FAIL indep_wrap got %b want 0100", wrap); end
        tick();
        checks++;
        if (wrap !== 4'b0000) begin errors++; $display("FAIL indep_wrap_width got %b want 0000", wrap); end
        release_all(p);
        $display("indep_wrap: dec=%h", dec);
    endtask

    task automatic test_chain_carry();
        logic [3:0] seen;
        logic       to;
        int         p;
        up = 1'b0; chain = 1'b0;
        step(4'b0010); step(4'b0010); step(4'b0001); step(4'b0001);
        checks++;
        if (dec !== 16'h0999) begin errors++; $display("FAIL chain_setup_0999 got %h want 0999", dec); end
        up = 1'b1; chain = 1'b1;
        hit(4'b0001, 1'b0, seen, to);
        checks++;
        if (dec !== 16'h1000) begin errors++; $display("FAIL chain_carry_dec got %h want 1000", dec); end
        checks++;
        if (wrap !== 4'b0111) begin errors++; $display("FAIL chain_carry_wrap got %b want 0111", wrap); end
        release_all(p);
        up = 1'b0; chain = 1'b0;
        step(4'b1000); step(4'b0001); step(4'b0010); step(4'b0100); step(4'b1000);
        checks++;
        if (dec !== 16'h9999) begin errors++; $display("FAIL chain_setup_9999 got %h want 9999", dec); end
        up = 1'b1; chain = 1'b1;
        hit(4'b0001, 1'b0, seen, to);
        checks++;
        if (dec !== 16'h0000) begin errors++; $display("FAIL chain_top_wrap_dec got %h want 0000", dec); end
        checks++;
        if (wrap !== 4'b1111) begin errors++; $display("FAIL chain_top_wrap_wrap got %b want 1111", wrap); end
        release_all(p);
        $display("chain_carry: dec=%h", dec);
    endtask

    task automatic test_chain_priority();
        logic [3:0] seen;
        logic       to;
        int         p;
        up = 1'b1; chain = 1'b1;
        hit(4'b1010, 1'b0, seen, to);
        checks++;
        if (to || seen !== 4'b1010) begin errors++; $display("FAIL prio_press got %b timeout %0d want 1010", seen, to); end
        checks++;
        if (dec !== 16'h0010) begin errors++; $display("FAIL prio_chain_dec got %h want 0010", dec); end
        release_all(p);
        clr = 1'b1; tick(); clr = 1'b0;
        checks++;
        if (dec !== 16'h0000) begin errors++; $display("FAIL clr_alone got %h want 0000", dec); end
        chain = 1'b0;
        hit(4'b1010, 1'b0, seen, to);
        checks++;
        if (dec !== 16'h1010) begin errors++; $display("FAIL prio_indep_dec got %h want 1010", dec); end
        release_all(p);
        up = 1'b0; chain = 1'b1;
        hit(4'b0001, 1'b0, seen, to);
        checks++;
        if (dec !== 16'h1009) begin errors++; $display("FAIL chain_borrow_dec got %h want 1009", dec); end
        checks++;
        if (wrap !== 4'b0001) begin errors++; $display("FAIL chain_borrow_wrap got %b want 0001", wrap); end
        release_all(p);
        $display("chain_priority: dec=%h", dec);
    endtask

    task automatic test_clr_press();
        logic [3:0] seen;
        logic       to;
        int         p;
        up = 1'b1; chain = 1'b0;
        hit(4'b0001, 1'b1, seen, to);
        checks++;
        if (to) begin errors++; $display("FAIL clr_press_timeout got timeout want press"); end
        checks++;
        if (dec !== 16'h0000) begin errors++; $display("FAIL clr_press_dec got %h want 0000", dec); end
        checks++;
        if (wrap !== 4'b0000) begin errors++; $display("FAIL clr_press_wrap got %b want 0000", wrap); end
        release_all(p);
        $display("clr_press: dec=%h wrap=%b", dec, wrap);
    endtask

    task automatic test_rst_mid_debounce();
        int p;
        up = 1'b1; chain = 1'b0;
        btn = 4'b0001;
        repeat (4) tick();
        checks++;
        if (press !== 4'b0) begin errors++; $display("FAIL rst_mid_pre got %b want 0000", press); end
        rst = 1'b1; tick(); rst = 1'b0;
        for (int e = 1; e <= 4; e++) begin
            tick();
            checks++;
            if (press !== 4'b0) begin errors++; $display("FAIL rst_mid_early edge %0d got %b want 0000", e, press); end
        end
        tick();
        checks++;
        if (press !== 4'b0001) begin errors++; $display("FAIL rst_mid_press got %b want 0001", press); end
        tick();
        checks++;
        if (dec !== 16'h0001) begin errors++; $display("FAIL rst_mid_dec got %h want 0001", dec); end
        release_all(p);
        $display("rst_mid_debounce: dec=%h", dec);
    endtask

    task automatic test_ce_hold();
        logic [3:0] seen;
        logic       to;
        int         p;
        up = 1'b1; chain = 1'b0;
        ce = 1'b0;
        btn = 4'b0001;
        p = 0;
        repeat (12) begin tick(); if (press != 4'b0) p++; end
        checks++;
        if (p != 0) begin errors++; $display("FAIL ce_hold_pulses got %0d want 0", p); end
        ce = 1'b1;
        hit(4'b0001, 1'b0, seen, to);
        checks++;
        if (to || dec !== 16'h0002) begin errors++; $display("FAIL ce_resume_dec got %h timeout %0d want 0002", dec, to); end
        release_all(p);
        $display("ce_hold: dec=%h", dec);
    endtask

    initial begin
        test_reset();
        test_latency();
        test_glitch();
        test_indep_wrap();
        test_chain_carry();
        test_chain_priority();
        test_clr_press();
        test_rst_mid_debounce();
        test_ce_hold();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
